// File: rtl/shift_right_seq_4bit.sv
// Multi-position logical right-shift sequencer with start/done handshake.
// Ports: clk, rst_n (sync, active-low), start, a, amount -> busy, done,
//        result, zero_flag, carry_flag.
module shift_right_seq_4bit #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [CNT_W-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
   output logic             carry_flag
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] shifted;
   logic             shift_out;

   // Single-position shift stage feeding back into the working register.
   assign shifted   = {1'b0, result[WIDTH-1:1]};
   assign shift_out = result[0];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (amount == '0) state_nx = DONE;
               else              state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == CNT_W'(1)) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result     <= '0;
         carry_flag <= 1'b0;
         cnt        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  result     <= a;
                  cnt        <= amount;
                  carry_flag <= 1'b0;
               end
            end
            SHIFT: begin
               result     <= shifted;
               carry_flag <= shift_out;
               cnt        <= cnt - CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign busy      = (state == SHIFT);
   assign done      = (state == DONE);
   assign zero_flag = (result == '0);

endmodule
